// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one ripple-carry adder between two requesters

module ripple_carry_adder #(
    parameter int A_W = 5,
    parameter int B_W = 4
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum
);

    logic [A_W-1:0] b_ext;

    assign b_ext = A_W'(b);

    // Bit-serial carry chain; the final carry-out is deliberately not exposed.
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < A_W; i++) begin
            sum[i] = a[i] ^ b_ext[i] ^ carry;
            carry  = (a[i] & b_ext[i]) | (carry & (a[i] ^ b_ext[i]));
        end
    end

endmodule

module adder_rr_arbiter #(
    parameter int A_W   = 5,
    parameter int B_W   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [A_W-1:0]   a0,
    input  logic [B_W-1:0]   b0,
    input  logic [A_W-1:0]   a1,
    input  logic [B_W-1:0]   b1,
    output logic [1:0]       req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [A_W-1:0]   resp_sum,
    output logic             resp_id,
    output logic             resp_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last_grant;
    logic           owner;
    logic           winner;
    logic [A_W-1:0] op_a;
    logic [B_W-1:0] op_b;
    logic [A_W-1:0] sum;

    ripple_carry_adder #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    // Winner: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = req_valid[1];
        end
    end

    // Next-state and accept strobe; accepts happen only from IDLE.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = winner ? 2'b10 : 2'b01;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, result registration and completion counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            resp_sum   <= '0;
            resp_id    <= 1'b0;
            resp_ovf   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        op_a       <= winner ? a1 : a0;
                        op_b       <= winner ? b1 : b0;
                        owner      <= winner;
                        last_grant <= winner;
                    end
                end
                EXEC: begin
                    resp_sum <= sum;
                    resp_ovf <= (sum < op_a);
                    resp_id  <= owner;
                end
                RESP: begin
                    if (resp_ready) begin
                        op_count <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed self-checking bench for adder_rr_arbiter

module tb_adder_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [4:0] a0, a1;
    logic [3:0] b0, b1;
    logic [1:0] req_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic [4:0] resp_sum;
    logic       resp_id;
    logic       resp_ovf;
    logic       busy;
    logic [7:0] op_count;

    int vectors    = 0;
    int miscompares = 0;

    adder_rr_arbiter #(.A_W(5), .B_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .resp_ovf   (resp_ovf),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; resp_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0; req_valid = 2'b00;
        #1;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        vectors++; if (resp_sum !== 5'd0) begin miscompares++; $display("FAIL reset_resp_sum got %0d want 0", resp_sum); end
        vectors++; if (resp_id !== 1'b0 || resp_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_id_ovf got %b%b want 00", resp_id, resp_ovf); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (op_count !== 8'd0) begin miscompares++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    endtask

    task automatic test_basic();
        resp_ready = 1'b1;
        cyc(); req_valid = 2'b01; a0 = 5'd3; b0 = 4'd4; #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL basic_req_ready got %b want 01", req_ready); end
        cyc(); req_valid = 2'b00; #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_exec got valid=%b busy=%b want 0 1", resp_valid, busy); end
        cyc(); #1;
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL basic_resp_valid got %b want 1", resp_valid); end
        vectors++; if (resp_sum !== 5'd7 || resp_id !== 1'b0 || resp_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_result got sum=%0d id=%b ovf=%b want 7 0 0", resp_sum, resp_id, resp_ovf); end
        cyc(); #1;
        vectors++; if (op_count !== 8'd1 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL basic_count got cnt=%0d valid=%b want 1 0", op_count, resp_valid); end
    endtask

    task automatic test_no_ovf_boundary();
        resp_ready = 1'b1;
        cyc(); req_valid = 2'b10; a1 = 5'd15; b1 = 4'd1; #1;
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bound_req_ready got %b want 10", req_ready); end
        cyc(); req_valid = 2'b00;
        cyc(); #1;
        vectors++; if (resp_sum !== 5'd16 || resp_id !== 1'b1 || resp_ovf !== 1'b0) begin miscompares++; $display("FAIL bound_result got sum=%0d id=%b ovf=%b want 16 1 0", resp_sum, resp_id, resp_ovf); end
        cyc(); #1;
        vectors++; if (op_count !== 8'd2) begin miscompares++; $display("FAIL bound_count got %0d want 2", op_count); end
    endtask

    task automatic test_wrap();
        logic [4:0] ta [2] = '{5'd31, 5'd31};
        logic [3:0] tb [2] = '{4'd15, 4'd1};
        logic [4:0] ts [2] = '{5'd14, 5'd0};
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); req_valid = 2'b01; a0 = ta[i]; b0 = tb[i];
            cyc(); req_valid = 2'b00;
            cyc(); #1;
            vectors++; if (resp_valid !== 1'b1 || resp_sum !== ts[i] || resp_ovf !== 1'b1) begin miscompares++; $display("FAIL wrap_%0d got valid=%b sum=%0d ovf=%b want 1 %0d 1", i, resp_valid, resp_sum, resp_ovf, ts[i]); end
            cyc();
        end
        #1;
        vectors++; if (op_count !== 8'd4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", op_count); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic       exp_id    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] exp_sum   [4] = '{5'd5, 5'd16, 5'd5, 5'd16};
        test_reset();
        resp_ready = 1'b1;
        a0 = 5'd2; b0 = 4'd3; a1 = 5'd10; b1 = 4'd6;
        for (int i = 0; i < 4; i++) begin
            cyc(); req_valid = 2'b11; #1;
            vectors++; if (req_ready !== exp_grant[i] || busy !== 1'b0) begin miscompares++; $display("FAIL rr_grant_%0d got %b busy=%b want %b 0", i, req_ready, busy, exp_grant[i]); end
            cyc(); #1;
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_exec_ready_%0d got %b want 00", i, req_ready); end
            cyc(); #1;
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_resp_ready_%0d got %b want 00", i, req_ready); end
            vectors++; if (resp_valid !== 1'b1 || resp_id !== exp_id[i] || resp_sum !== exp_sum[i]) begin miscompares++; $display("FAIL rr_result_%0d got valid=%b id=%b sum=%0d want 1 %b %0d", i, resp_valid, resp_id, resp_sum, exp_id[i], exp_sum[i]); end
        end
        cyc(); req_valid = 2'b00; #1;
        vectors++; if (op_count !== 8'd4) begin miscompares++; $display("FAIL rr_count got %0d want 4", op_count); end
    endtask

    task automatic test_back_pressure();
        resp_ready = 1'b0;
        a0 = 5'd20; b0 = 4'd9; a1 = 5'd1; b1 = 4'd1;
        cyc(); req_valid = 2'b11; #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_grant got %b want 01", req_ready); end
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            vectors++; if (resp_valid !== 1'b1 || resp_sum !== 5'd29 || resp_id !== 1'b0) begin miscompares++; $display("FAIL bp_hold_%0d got valid=%b sum=%0d id=%b want 1 29 0", i, resp_valid, resp_sum, resp_id); end
            vectors++; if (req_ready !== 2'b00 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_stall_%0d got ready=%b busy=%b want 00 1", i, req_ready, busy); end
        end
        resp_ready = 1'b1;
        cyc(); #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd5) begin miscompares++; $display("FAIL bp_release got valid=%b busy=%b cnt=%0d want 0 0 5", resp_valid, busy, op_count); end
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
        req_valid = 2'b00;
        cyc(); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        resp_ready = 1'b0;
        cyc(); req_valid = 2'b10; a1 = 5'd5; b1 = 4'd5;
        cyc(); req_valid = 2'b00; rst = 1'b1;
        cyc(); rst = 1'b0; #1;
        vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin miscompares++; $display("FAIL rst_exec got valid=%b busy=%b cnt=%0d want 0 0 0", resp_valid, busy, op_count); end
        cyc(); #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_exec_nopulse got %b want 0", resp_valid); end
        req_valid = 2'b01; a0 = 5'd7; b0 = 4'd2;
        cyc(); req_valid = 2'b00;
        cyc(); #1;
        vectors++; if (resp_valid !== 1'b1 || resp_sum !== 5'd9) begin miscompares++; $display("FAIL rst_resp_setup got valid=%b sum=%0d want 1 9", resp_valid, resp_sum); end
        rst = 1'b1; resp_ready = 1'b1;
        cyc(); rst = 1'b0; #1;
        vectors++; if (resp_valid !== 1'b0 || resp_sum !== 5'd0 || resp_id !== 1'b0 || resp_ovf !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin miscompares++; $display("FAIL rst_resp got valid=%b sum=%0d id=%b ovf=%b busy=%b cnt=%0d want all 0", resp_valid, resp_sum, resp_id, resp_ovf, busy, op_count); end
        req_valid = 2'b11; a0 = 5'd1; b0 = 4'd1; a1 = 5'd8; b1 = 4'd8; #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_tie got %b want 01", req_ready); end
        cyc(); req_valid = 2'b00;
        cyc(); #1;
        vectors++; if (resp_id !== 1'b0 || resp_sum !== 5'd2) begin miscompares++; $display("FAIL rst_tie_result got id=%b sum=%0d want 0 2", resp_id, resp_sum); end
        cyc(); #1;
        vectors++; if (op_count !== 8'd1) begin miscompares++; $display("FAIL rst_tie_count got %0d want 1", op_count); end
    endtask

    task automatic test_count_wrap();
        test_reset();
        resp_ready = 1'b1; a0 = 5'd1; b0 = 4'd1;
        for (int i = 0; i < 255; i++) begin
            cyc(); req_valid = 2'b01;
            cyc(); req_valid = 2'b00;
            cyc();
        end
        cyc(); #1;
        vectors++; if (op_count !== 8'd255) begin miscompares++; $display("FAIL cnt_max got %0d want 255", op_count); end
        req_valid = 2'b01;
        cyc(); req_valid = 2'b00;
        cyc(); cyc(); #1;
        vectors++; if (op_count !== 8'd0) begin miscompares++; $display("FAIL cnt_wrap got %0d want 0", op_count); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_basic();
        test_no_ovf_boundary();
        test_wrap();
        test_round_robin();
        test_back_pressure();
        test_reset_mid_op();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
